// File: rtl/mem_access_ctrl_pkg.sv
// mem_access_ctrl_pkg: request opcodes, exception codes, FSM states and opcode decode helpers
package mem_access_ctrl_pkg;

    localparam int DM_ADDR_W = 15;

    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;

    typedef enum logic [2:0] {
        OP_LW  = 3'd0,
        OP_LH  = 3'd1,
        OP_LHU = 3'd2,
        OP_LB  = 3'd3,
        OP_LBU = 3'd4,
        OP_SW  = 3'd5,
        OP_SH  = 3'd6,
        OP_SB  = 3'd7
    } op_e;

    typedef enum logic {
        IDLE    = 1'b0,
        RD_WAIT = 1'b1
    } state_e;

    function automatic logic is_store(op_e op);
        return op == OP_SW || op == OP_SH || op == OP_SB;
    endfunction

    function automatic logic is_word(op_e op);
        return op == OP_LW || op == OP_SW;
    endfunction

    function automatic logic is_half(op_e op);
        return op == OP_LH || op == OP_LHU || op == OP_SH;
    endfunction

endpackage

// File: rtl/mem_access_ctrl_load_ext.sv
// mem_access_ctrl_load_ext: selects the loaded lane from the read word and sign/zero-extends it
module mem_access_ctrl_load_ext
    import mem_access_ctrl_pkg::*;
(
    input  op_e         op_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] word_i,
    output logic [31:0] data_o
);

    logic [7:0]  b;
    logic [15:0] h;

    assign b = word_i[8*off_i +: 8];
    assign h = off_i[1] ? word_i[31:16] : word_i[15:0];

    // Extension by opcode; anything that is not a sub-word load passes the word through
    always_comb begin
        data_o = op_i == OP_LB  ? {{24{b[7]}}, b}  :
                 op_i == OP_LBU ? {24'b0, b}       :
                 op_i == OP_LH  ? {{16{h[15]}}, h} :
                 op_i == OP_LHU ? {16'b0, h}       :
                                  word_i;
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: MEM-stage load/store controller in front of a 1-cycle-latency data memory.
// Define DM_BOUND_CHECK_EN to turn accesses above the decoded memory range into address errors.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        clr,
    input  logic        flush,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic [31:0] dm_addr,
    output logic [3:0]  dm_be,
    output logic        dm_we,
    output logic [31:0] dm_wd,
    input  logic [31:0] dm_dr,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_exc,
    output logic [4:0]  resp_exccode
);

    state_e      state_q;
    op_e         op_q;
    logic [1:0]  off_q;
    logic        resp_valid_q;
    logic [31:0] resp_rdata_q;
    logic        resp_exc_q;
    logic [4:0]  resp_exccode_q;

    op_e         op;
    logic [1:0]  off;
    logic        acc;
    logic        st;
    logic        misal;
    logic        oob;
    logic        bad;
    logic        go;
    logic [3:0]  be;
    logic [31:0] ext;

    assign op  = op_e'(req_op);
    assign off = req_addr[1:0];
    assign st  = is_store(op);

    assign req_ready = state_q == IDLE && !flush;
    assign acc       = req_valid && req_ready;

    assign misal = is_word(op) ? off != 2'd0 : is_half(op) ? off[0] : 1'b0;

`ifdef DM_BOUND_CHECK_EN
    assign oob = |req_addr[31:DM_ADDR_W];
`else
    assign oob = 1'b0;
`endif

    assign bad = misal || oob;
    assign go  = acc && !bad;

    assign be = is_word(op) ? 4'b1111 :
                is_half(op) ? (off[1] ? 4'b1100 : 4'b0011) :
                              4'b0001 << off;

    // Memory side is driven only for an accepted, well-formed access; idle otherwise
    always_comb begin
        dm_we   = go && st;
        dm_be   = go ? be : 4'b0;
        dm_addr = go ? req_addr : 32'b0;
        dm_wd   = go && st ? req_wdata : 32'b0;
    end

    mem_access_ctrl_load_ext u_load_ext (
        .op_i   (op_q),
        .off_i  (off_q),
        .word_i (dm_dr),
        .data_o (ext)
    );

    // Request FSM with registered response; a response field holds until the next response
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q        <= IDLE;
            op_q           <= OP_LW;
            off_q          <= 2'd0;
            resp_valid_q   <= 1'b0;
            resp_rdata_q   <= 32'b0;
            resp_exc_q     <= 1'b0;
            resp_exccode_q <= 5'd0;
        end else begin
            resp_valid_q <= 1'b0;
            if (state_q == IDLE) begin
                if (acc && bad) begin
                    resp_valid_q   <= 1'b1;
                    resp_rdata_q   <= 32'b0;
                    resp_exc_q     <= 1'b1;
                    resp_exccode_q <= st ? EXC_ADES : EXC_ADEL;
                end else if (acc && st) begin
                    resp_valid_q   <= 1'b1;
                    resp_rdata_q   <= 32'b0;
                    resp_exc_q     <= 1'b0;
                    resp_exccode_q <= 5'd0;
                end else if (acc) begin
                    op_q    <= op;
                    off_q   <= off;
                    state_q <= RD_WAIT;
                end
            end else begin
                state_q <= IDLE;
                if (!flush) begin
                    resp_valid_q   <= 1'b1;
                    resp_rdata_q   <= ext;
                    resp_exc_q     <= 1'b0;
                    resp_exccode_q <= 5'd0;
                end
            end
        end
    end

    assign resp_valid   = resp_valid_q;
    assign resp_rdata   = resp_rdata_q;
    assign resp_exc     = resp_exc_q;
    assign resp_exccode = resp_exccode_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed checks of mem_access_ctrl against a byte-enabled synchronous RAM model
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        clr;
    logic        flush;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [31:0] dm_addr;
    logic [3:0]  dm_be;
    logic        dm_we;
    logic [31:0] dm_wd;
    logic [31:0] dm_dr;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_exc;
    logic [4:0]  resp_exccode;

    int checks = 0;
    int failures = 0;

    logic [31:0] mem [0:8191];

    mem_access_ctrl dut (
        .clk          (clk),
        .clr          (clr),
        .flush        (flush),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op       (req_op),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .dm_addr      (dm_addr),
        .dm_be        (dm_be),
        .dm_we        (dm_we),
        .dm_wd        (dm_wd),
        .dm_dr        (dm_dr),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_exc     (resp_exc),
        .resp_exccode (resp_exccode)
    );

    always #5 clk = ~clk;

    // Data memory: lane placement from byte enables, registered read
    always @(posedge clk) begin
        if (dm_we) begin
            case (dm_be)
                4'b1111: mem[dm_addr[14:2]] = dm_wd;
                4'b0011: mem[dm_addr[14:2]][15:0] = dm_wd[15:0];
                4'b1100: mem[dm_addr[14:2]][31:16] = dm_wd[15:0];
                4'b0001: mem[dm_addr[14:2]][7:0] = dm_wd[7:0];
                4'b0010: mem[dm_addr[14:2]][15:8] = dm_wd[7:0];
                4'b0100: mem[dm_addr[14:2]][23:16] = dm_wd[7:0];
                4'b1000: mem[dm_addr[14:2]][31:24] = dm_wd[7:0];
                default: ;
            endcase
        end
        dm_dr <= mem[dm_addr[14:2]];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd);
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        req_wdata = wd;
        #1;
    endtask

    task automatic store(input string tag, input logic [2:0] op, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [3:0] be);
        drive(op, addr, wd);
        chk({tag, "_we"}, {31'b0, dm_we}, 32'd1);
        chk({tag, "_be"}, {28'b0, dm_be}, {28'b0, be});
        tick();
        req_valid = 1'b0;
        chk({tag, "_rv"}, {31'b0, resp_valid}, 32'd1);
        chk({tag, "_exc"}, {31'b0, resp_exc}, 32'd0);
    endtask

    task automatic load(input string tag, input logic [2:0] op, input logic [31:0] addr,
                        input logic [31:0] exp);
        drive(op, addr, 32'h0);
        tick();
        req_valid = 1'b0;
        chk({tag, "_wait_rv"}, {31'b0, resp_valid}, 32'd0);
        tick();
        chk({tag, "_rv"}, {31'b0, resp_valid}, 32'd1);
        chk({tag, "_rdata"}, resp_rdata, exp);
    endtask

    initial begin
        for (int i = 0; i < 8192; i++) mem[i] = 32'h0;
        clr = 1'b1;
        flush = 1'b0;
        req_valid = 1'b0;
        req_op = 3'd0;
        req_addr = 32'h0;
        req_wdata = 32'h0;
        repeat (2) tick();
        clr = 1'b0;
        #1;
        chk("rst_rv", {31'b0, resp_valid}, 32'd0);
        chk("rst_rdata", resp_rdata, 32'h0);
        chk("rst_exc", {31'b0, resp_exc}, 32'd0);
        chk("rst_code", {27'b0, resp_exccode}, 32'd0);
        chk("rst_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_dm_be", {28'b0, dm_be}, 32'd0);
        chk("rst_dm_addr", dm_addr, 32'h0);

        // SW then LW; check memory-side drive and RD_WAIT stall
        drive(3'd5, 32'h100, 32'h1234_5678);
        chk("sw_addr", dm_addr, 32'h100);
        chk("sw_wd", dm_wd, 32'h1234_5678);
        req_valid = 1'b0;
        store("sw", 3'd5, 32'h100, 32'h1234_5678, 4'b1111);
        chk("sw_rdata", resp_rdata, 32'h0);
        drive(3'd0, 32'h100, 32'h0);
        chk("lw_we", {31'b0, dm_we}, 32'd0);
        chk("lw_be", {28'b0, dm_be}, 32'hf);
        tick();
        req_valid = 1'b0;
        chk("lw_ready_wait", {31'b0, req_ready}, 32'd0);
        chk("lw_rv_wait", {31'b0, resp_valid}, 32'd0);
        tick();
        chk("lw_rv", {31'b0, resp_valid}, 32'd1);
        chk("lw_rdata", resp_rdata, 32'h1234_5678);
        chk("lw_ready", {31'b0, req_ready}, 32'd1);

        // Lane select and extension on 0x80FF7F01
        store("sw2", 3'd5, 32'h200, 32'h80FF_7F01, 4'b1111);
        drive(3'd3, 32'h203, 32'h0);
        chk("lb3_be", {28'b0, dm_be}, 32'h8);
        req_valid = 1'b0;
        load("lb3", 3'd3, 32'h203, 32'hFFFF_FF80);
        load("lbu3", 3'd4, 32'h203, 32'h0000_0080);
        load("lb0", 3'd3, 32'h200, 32'h0000_0001);
        load("lh2", 3'd1, 32'h202, 32'hFFFF_80FF);
        load("lhu0", 3'd2, 32'h200, 32'h0000_7F01);
        load("lbu1", 3'd4, 32'h201, 32'h0000_007F);

        // Sub-word stores
        drive(3'd6, 32'h102, 32'h0000_ABCD);
        chk("sh_wd", dm_wd, 32'h0000_ABCD);
        req_valid = 1'b0;
        store("sh", 3'd6, 32'h102, 32'h0000_ABCD, 4'b1100);
        store("sb", 3'd7, 32'h101, 32'h0000_00EF, 4'b0010);
        load("lw_merged", 3'd0, 32'h100, 32'hABCD_EF78);

        // Misaligned accesses
        drive(3'd0, 32'h102, 32'h0);
        chk("adel_we", {31'b0, dm_we}, 32'd0);
        chk("adel_be", {28'b0, dm_be}, 32'd0);
        tick();
        req_valid = 1'b0;
        chk("adel_rv", {31'b0, resp_valid}, 32'd1);
        chk("adel_exc", {31'b0, resp_exc}, 32'd1);
        chk("adel_code", {27'b0, resp_exccode}, 32'd4);
        chk("adel_rdata", resp_rdata, 32'h0);
        chk("adel_ready", {31'b0, req_ready}, 32'd1);
        drive(3'd6, 32'h101, 32'h1234);
        chk("ades_we", {31'b0, dm_we}, 32'd0);
        tick();
        req_valid = 1'b0;
        chk("ades_rv", {31'b0, resp_valid}, 32'd1);
        chk("ades_code", {27'b0, resp_exccode}, 32'd5);
        tick();
        chk("hold_rv", {31'b0, resp_valid}, 32'd0);
        chk("hold_exc", {31'b0, resp_exc}, 32'd1);
        chk("hold_code", {27'b0, resp_exccode}, 32'd5);

        // Flush in RD_WAIT suppresses the response
        drive(3'd0, 32'h100, 32'h0);
        tick();
        req_valid = 1'b0;
        flush = 1'b1;
        #1;
        chk("flush_ready", {31'b0, req_ready}, 32'd0);
        tick();
        flush = 1'b0;
        #1;
        chk("flush_rv", {31'b0, resp_valid}, 32'd0);
        chk("flush_ready_after", {31'b0, req_ready}, 32'd1);
        tick();
        chk("flush_rv_late", {31'b0, resp_valid}, 32'd0);

        // Flush in IDLE blocks acceptance
        flush = 1'b1;
        drive(3'd5, 32'h300, 32'hDEAD_BEEF);
        chk("flush_idle_ready", {31'b0, req_ready}, 32'd0);
        chk("flush_idle_we", {31'b0, dm_we}, 32'd0);
        tick();
        req_valid = 1'b0;
        flush = 1'b0;
        #1;
        chk("flush_idle_rv", {31'b0, resp_valid}, 32'd0);
        load("flush_idle_mem", 3'd0, 32'h300, 32'h0);

        // clr while a load is in flight
        load("pre_clr", 3'd0, 32'h200, 32'h80FF_7F01);
        drive(3'd0, 32'h100, 32'h0);
        tick();
        req_valid = 1'b0;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        #1;
        chk("clr_rv", {31'b0, resp_valid}, 32'd0);
        chk("clr_rdata", resp_rdata, 32'h0);
        chk("clr_exc", {31'b0, resp_exc}, 32'd0);
        chk("clr_code", {27'b0, resp_exccode}, 32'd0);
        chk("clr_ready", {31'b0, req_ready}, 32'd1);
        tick();
        chk("clr_rv_late", {31'b0, resp_valid}, 32'd0);

        // Upper address bits beyond the memory range
        store("sw0", 3'd5, 32'h0, 32'hCAFE_F00D, 4'b1111);
`ifdef DM_BOUND_CHECK_EN
        drive(3'd0, 32'h0000_8000, 32'h0);
        chk("oob_be", {28'b0, dm_be}, 32'd0);
        tick();
        req_valid = 1'b0;
        chk("oob_rv", {31'b0, resp_valid}, 32'd1);
        chk("oob_exc", {31'b0, resp_exc}, 32'd1);
        chk("oob_code", {27'b0, resp_exccode}, 32'd4);
`else
        load("alias", 3'd0, 32'h0000_8000, 32'hCAFE_F00D);
        chk("alias_exc", {31'b0, resp_exc}, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
